mda_frame_capture: RTL and testbench

Captures the MDA pixel stream (video, intensity, display enable, syncs) produced by the MDA core and writes it into the HDMI-side frame buffer as packed 2-bit pixels. Sits directly downstream of the MDA core and upstream of the frame-buffer write port. It locks to vsync and hsync/display-enable, counts active pixels and lines, and packs 4 pixels per byte. Writes are buffered through a small FIFO with valid/ready back-pressure.

---
 rtl/mda_capture_pkg.sv | 22 ++
 rtl/capture_fifo.sv | 43 ++++
 rtl/mda_frame_capture.sv | 145 ++++++++++++++
 tb/tb_mda_frame_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mda_capture_pkg.sv
// mda_capture_pkg: shared FSM state, pixel codes and line geometry for MDA frame capture
package mda_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC,
        WAIT_LINE,
        CAPTURE
    } cap_state_t;

    localparam logic [1:0] PIX_BLACK  = 2'b00;
    localparam logic [1:0] PIX_NORMAL = 2'b01;
    localparam logic [1:0] PIX_BRIGHT = 2'b11;

    function automatic int bytes_per_line(input int h_active);
        return h_active / 4;
    endfunction

    function automatic logic [1:0] pix_code(input logic video, input logic intensity);
        return video ? (intensity ? PIX_BRIGHT : PIX_NORMAL) : PIX_BLACK;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: small synchronous FIFO; a push on full succeeds only alongside a pop
module capture_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_wr, do_rd;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage is cleared so the read port shows zero out of reset.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mda_frame_capture.sv
// mda_frame_capture: locks to MDA syncs, packs 2-bit pixels 4 per byte and queues frame-buffer writes
module mda_frame_capture
    import mda_capture_pkg::*;
#(
    parameter int H_ACTIVE   = 720,
    parameter int V_ACTIVE   = 350,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              pix_stb,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              display_enable,
    input  logic              video,
    input  logic              intensity,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              frame_done,
    output logic              overflow,
    output logic              locked
);

    localparam int BYTES_PER_LINE = bytes_per_line(H_ACTIVE);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(H_ACTIVE);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

    cap_state_t          state, state_n;
    logic [LW-1:0]       line, line_n;
    logic [CW-1:0]       col, col_n;
    logic [ADDR_W-1:0]   line_base, base_n;
    logic [5:0]          sh, sh_n;
    logic                vs_q, hs_q, de_q;
    logic                vs_rise, hs_rise, de_fall;
    logic [1:0]          code, pad;
    logic [7:0]          flush;
    logic                push, pop, full, empty, drop, done_n;
    logic [ADDR_W-1:0]   push_addr;
    logic [7:0]          push_data;
    logic [ADDR_W+7:0]   fifo_out;

    assign code      = pix_code(video, intensity);
    assign vs_rise   = vsync & ~vs_q;
    assign hs_rise   = hsync & ~hs_q;
    assign de_fall   = ~display_enable & de_q;
    // Left-justify the 1-3 pending pixels; vacated slots read as black.
    assign pad       = 2'd3 - col[1:0];
    assign flush     = {sh, 2'b00} << {pad, 1'b0};
    assign push_addr = line_base + ADDR_W'(col >> 2);
    assign pop       = fb_valid & fb_ready;
    assign drop      = push & full & ~pop;
    assign fb_valid  = ~empty;
    assign {fb_addr, fb_data} = fifo_out;

    always_comb begin
        state_n   = state;
        line_n    = line;
        col_n     = col;
        base_n    = line_base;
        sh_n      = sh;
        push      = 1'b0;
        push_data = {sh, code};
        done_n    = 1'b0;
        if (pix_stb) begin
            if (vs_rise) begin
                state_n = WAIT_LINE;
                line_n  = '0;
                col_n   = '0;
                base_n  = '0;
            end else begin
                case (state)
                    WAIT_LINE: if (display_enable && line <= LINE_LAST) begin
                        state_n = CAPTURE;
                        col_n   = CW'(1);
                        sh_n    = {sh[3:0], code};
                    end
                    CAPTURE: if (de_fall || hs_rise) begin
                        push      = col[1:0] != 2'd0;
                        push_data = flush;
                        line_n    = line + 1'b1;
                        base_n    = line_base + ADDR_W'(BYTES_PER_LINE);
                        col_n     = '0;
                        done_n    = line == LINE_LAST;
                        state_n   = done_n ? WAIT_VSYNC : WAIT_LINE;
                    end else if (display_enable && col < COL_MAX) begin
                        push  = col[1:0] == 2'd3;
                        sh_n  = {sh[3:0], code};
                        col_n = col + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= WAIT_VSYNC;
            line       <= '0;
            col        <= '0;
            line_base  <= '0;
            sh         <= '0;
            vs_q       <= 1'b0;
            hs_q       <= 1'b0;
            de_q       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_n;
            line       <= line_n;
            col        <= col_n;
            line_base  <= base_n;
            sh         <= sh_n;
            if (pix_stb) begin
                vs_q <= vsync;
                hs_q <= hsync;
                de_q <= display_enable;
            end
            frame_done <= done_n;
            overflow   <= (pix_stb & vs_rise) ? 1'b0 : overflow | drop;
            locked     <= locked | (pix_stb & vs_rise);
        end
    end

    capture_fifo #(
        .W     (ADDR_W + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (push),
        .din     ({push_addr, push_data}),
        .pop     (pop),
        .dout    (fifo_out),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_mda_frame_capture.sv
// tb_mda_frame_capture: directed and randomized capture scenarios checked against a packing model
module tb_mda_frame_capture;

    localparam int H = 720, V = 20, BPL = H / 4;

    logic clk = 0, reset_l = 0, pix_stb = 0, hsync = 0, vsync = 0;
    logic display_enable = 0, video = 0, intensity = 0, fb_ready = 1;
    logic fb_valid, frame_done, overflow, locked;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;

    int errors = 0, checks = 0, rdy_mode = 0, done_cnt = 0, gi = 0, d0 = 0, last_n = 0;
    logic [23:0] got[$], exp_q[$];
    logic [1:0]  px[$];

    always #5 clk = ~clk;

    mda_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4), .ADDR_W(16)) dut (
        .clk(clk), .reset_l(reset_l), .pix_stb(pix_stb), .hsync(hsync), .vsync(vsync),
        .display_enable(display_enable), .video(video), .intensity(intensity),
        .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_done(frame_done), .overflow(overflow), .locked(locked)
    );

    always @(negedge clk) begin
        if (reset_l && fb_valid && fb_ready) got.push_back({fb_addr, fb_data});
        if (frame_done) done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready();
        fb_ready = rdy_mode == 2 ? 1'b0 : rdy_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic strobe(input logic hs, input logic vs, input logic de, input logic [1:0] p);
        hsync = hs; vsync = vs; display_enable = de; video = p[1]; intensity = p[0];
        pix_stb = 1; set_ready();
        @(posedge clk); #1;
        pix_stb = 0; set_ready();
        @(posedge clk); #1;
    endtask

    task automatic vsync_pulse();
        strobe(0, 1, 0, 2'b00);
        strobe(0, 0, 0, 2'b00);
    endtask

    task automatic gen_line(input int n);
        px.delete();
        for (int i = 0; i < n; i++) px.push_back(2'($urandom_range(0, 3)));
    endtask

    task automatic send_line(input bit hs_end);
        for (int i = 0; i < px.size(); i++) strobe(0, 0, 1, px[i]);
        if (hs_end) strobe(1, 0, 1, 2'($urandom_range(0, 3)));
        strobe(0, 0, 0, 2'b00);
        strobe(0, 0, 0, 2'b00);
    endtask

    // px entries are {video,intensity}; black whenever video is low.
    task automatic model_line(input int ln, input bit keep_partial);
        int n, nb;
        logic [7:0] d;
        n  = px.size() > H ? H : px.size();
        nb = keep_partial ? (n + 3) / 4 : n / 4;
        for (int b = 0; b < nb; b++) begin
            d = 8'h00;
            for (int k = 0; k < 4; k++)
                if (4 * b + k < n && px[4 * b + k][1])
                    d = d | (8'(px[4 * b + k][0] ? 3 : 1) << (6 - 2 * k));
            exp_q.push_back({16'(ln * BPL + b), d});
        end
    endtask

    task automatic compare_writes(input string tag);
        int k;
        rdy_mode = 0; fb_ready = 1; k = 0;
        while (fb_valid && k < 64) begin @(posedge clk); #1; k++; end
        check({tag, " drained"}, 32'(fb_valid), 32'd0);
        check({tag, " count"}, 32'(got.size() - gi), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && gi + i < got.size(); i++)
            check($sformatf("%s w%0d", tag, i), 32'(got[gi + i]), 32'(exp_q[i]));
        gi = got.size();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk); #1;
        check("rst fb_valid", 32'(fb_valid), 0);
        check("rst fb_addr", 32'(fb_addr), 0);
        check("rst fb_data", 32'(fb_data), 0);
        check("rst frame_done", 32'(frame_done), 0);
        check("rst overflow", 32'(overflow), 0);
        check("rst locked", 32'(locked), 0);
        reset_l = 1;
        @(posedge clk); #1;

        gen_line(16); send_line(0);
        compare_writes("prelock");
        check("prelock locked", 32'(locked), 0);

        vsync_pulse();
        check("locked", 32'(locked), 1);
        px.delete();
        repeat (H) px.push_back(2'b10);
        for (int b = 0; b < BPL; b++) exp_q.push_back({16'(b), 8'h55});
        send_line(0);
        compare_writes("line55");

        vsync_pulse();
        px = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
        exp_q = '{24'h0000D3, 24'h0001F0};
        send_line(0);
        compare_writes("partial");

        vsync_pulse();
        rdy_mode = 1;
        for (int l = 0; l < 3; l++) begin
            gen_line($urandom_range(1, 730));
            model_line(l, 1);
            send_line(l == 2);
        end
        compare_writes("random");
        check("random overflow", 32'(overflow), 0);

        vsync_pulse();
        gen_line(32); model_line(0, 1); exp_q.delete(4);
        for (int j = 0; j < 32; j++) begin
            rdy_mode = j < 20 ? 2 : 0;
            strobe(0, 0, 1, px[j]);
            if (j == 8 || j == 19) begin
                check($sformatf("stall valid %0d", j), 32'(fb_valid), 1);
                check($sformatf("stall head %0d", j), 32'({fb_addr, fb_data}), 32'(exp_q[0]));
            end
            if (j == 19) check("overflow set", 32'(overflow), 1);
        end
        strobe(0, 0, 0, 2'b00); strobe(0, 0, 0, 2'b00);
        compare_writes("overflow");
        check("overflow sticky", 32'(overflow), 1);
        vsync_pulse();
        check("overflow cleared", 32'(overflow), 0);

        d0 = done_cnt;
        rdy_mode = 1;
        for (int l = 0; l < V + 5; l++) begin
            gen_line($urandom_range(1, 12));
            if (l < V) model_line(l, 1);
            if (l == V - 1) last_n = px.size();
            send_line(0);
        end
        compare_writes("frame");
        check("frame_done once", 32'(done_cnt - d0), 1);
        check("frame last addr", 32'(got[got.size() - 1][23:8]), 32'((V - 1) * BPL + (last_n + 3) / 4 - 1));

        vsync_pulse();
        d0 = done_cnt;
        for (int l = 0; l < 10; l++) begin
            gen_line($urandom_range(1, 12)); model_line(l, 1); send_line(0);
        end
        gen_line(6); model_line(10, 0);
        for (int j = 0; j < 6; j++) strobe(0, 0, 1, px[j]);
        strobe(0, 1, 1, 2'b11);
        strobe(0, 0, 0, 2'b00); strobe(0, 0, 0, 2'b00);
        gen_line(8); model_line(0, 1); send_line(0);
        compare_writes("midvsync");
        check("midvsync no frame_done", 32'(done_cnt - d0), 0);

        vsync_pulse();
        rdy_mode = 2;
        gen_line(8);
        for (int j = 0; j < 8; j++) strobe(0, 0, 1, px[j]);
        check("pre-reset valid", 32'(fb_valid), 1);
        reset_l = 0; #1;
        check("async reset valid", 32'(fb_valid), 0);
        check("async reset locked", 32'(locked), 0);
        check("async reset overflow", 32'(overflow), 0);
        @(posedge clk); #1;
        reset_l = 1; rdy_mode = 0; fb_ready = 1;
        strobe(0, 0, 0, 2'b00);
        gen_line(8); send_line(0);
        compare_writes("post-reset unlocked");
        check("post-reset locked", 32'(locked), 0);
        vsync_pulse();
        gen_line(8); model_line(0, 1); send_line(0);
        compare_writes("relock");
        check("relock locked", 32'(locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
